// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared definitions for the control-bundle pipeline: FSM encoding, bubble
// constant and a saturating counter helper.
package ctrl_pipe_chain_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_t;

    // A bubble is valid=0 with an all-zero control bundle.
    localparam logic BUBBLE_VALID = 1'b0;
    localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? BUBBLE_CNT_MAX : sum[15:0];
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Decode-side input handshake and retire-side output of the control pipeline.
interface ctrl_pipe_chain_if #(
    parameter int W = 16
);
    logic [W-1:0] in_ctrl;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_ctrl;
    logic         out_valid;

    modport master (
        output in_ctrl, in_valid,
        input  in_ready, out_ctrl, out_valid
    );

    modport slave (
        input  in_ctrl, in_valid,
        output in_ready, out_ctrl, out_valid
    );
endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// One pipeline slot: valid + ctrl register, priority reset > flush > hold > load.
module ctrl_pipe_stage
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         hold,
    input  logic         load_valid,
    input  logic [W-1:0] load_ctrl,
    output logic         valid,
    output logic [W-1:0] ctrl,
    output logic         valid_next
);

    logic [W-1:0] ctrl_next;

    // ctrl is masked on load so an invalid slot never carries stale bits.
    always_comb begin
        valid_next = valid;
        ctrl_next  = ctrl;
        if (flush) begin
            valid_next = BUBBLE_VALID;
            ctrl_next  = '0;
        end else if (!hold) begin
            valid_next = load_valid;
            ctrl_next  = load_valid ? load_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= BUBBLE_VALID;
            ctrl  <= '0;
        end else begin
            valid <= valid_next;
            ctrl  <= ctrl_next;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline with per-stage stall, youngest-stage flush and a
// halt/drain sequencer.
module ctrl_pipe_chain
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int W           = 16,
    parameter int STAGES      = 3,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    ctrl_pipe_chain_if.slave                 bus,
    input  logic [STAGES-1:0]                stall_at,
    input  logic                             flush,
    input  logic                             halt_req,
    input  logic                             resume,
    output logic [STAGES-1:0]                stage_valid,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic                             drained,
    output logic [15:0]                      bubble_cnt
);

    // state     | meaning
    // ST_RUN    | accepting bundles from decode
    // ST_DRAIN  | input closed, waiting for every stage to empty
    // ST_HALTED | pipe empty, waiting for resume

    localparam int OCC_W = $clog2(STAGES + 1);

    pipe_state_t       state_q, state_d;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bubble_at;
    logic [STAGES-1:0] flush_at;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] load_valid;
    logic [W-1:0]      load_ctrl  [STAGES];
    logic [W-1:0]      stage_ctrl [STAGES];
    logic              in_ready;

    assign in_ready = (state_q == ST_RUN) && !hold[0] && !flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stall anywhere downstream holds this stage too.
        assign hold[k]     = |(stall_at >> k);
        assign flush_at[k] = flush && (k < FLUSH_DEPTH);

        if (k == 0) begin : g_head
            assign bubble_at[k]  = 1'b0;
            assign load_valid[k] = in_ready ? bus.in_valid : BUBBLE_VALID;
            assign load_ctrl[k]  = in_ready ? bus.in_ctrl : '0;
        end else begin : g_body
            assign bubble_at[k]  = hold[k-1] && !hold[k];
            assign load_valid[k] = bubble_at[k] ? BUBBLE_VALID : stage_valid[k-1];
            assign load_ctrl[k]  = bubble_at[k] ? '0 : stage_ctrl[k-1];
        end

        ctrl_pipe_stage #(.W(W)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush_at[k]),
            .hold       (hold[k]),
            .load_valid (load_valid[k]),
            .load_ctrl  (load_ctrl[k]),
            .valid      (stage_valid[k]),
            .ctrl       (stage_ctrl[k]),
            .valid_next (valid_next[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (valid_next == '0) state_d = ST_HALTED;
            ST_HALTED: if (resume && !halt_req) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Flush overrides a stall bubble in the youngest stages, so those are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            occupancy  <= '0;
            bubble_cnt <= '0;
        end else begin
            state_q    <= state_d;
            occupancy  <= OCC_W'($countones(valid_next));
            bubble_cnt <= sat_add16(bubble_cnt, 16'($countones(bubble_at & ~flush_at)));
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = stage_valid[STAGES-1];
    assign bus.out_ctrl  = stage_ctrl[STAGES-1];
    assign drained       = (state_q == ST_HALTED);

endmodule

// File: doc/ctrl_pipe_chain.md
CTRL_PIPE_CHAIN -- requirements
Module: ctrl_pipe_chain

Interface
REQ-001 Parameter: W, 16, width of one control bundle.
REQ-002 Parameter: STAGES, 3, number of pipeline register stages (range 2..8).
REQ-003 Parameter: FLUSH_DEPTH, 1, number of youngest stages (0..FLUSH_DEPTH-1) cleared by flush (range 1..STAGES).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: in_ctrl  in  W  control bundle from decode.
REQ-007 Port: in_valid  in  1  in_ctrl carries a real instruction.
REQ-008 Port: in_ready  out  1  stage 0 will capture in_ctrl this cycle.
REQ-009 Port: stall_at  in  STAGES  bit k requests stage k hold its contents.
REQ-010 Port: flush  in  1  squash the youngest FLUSH_DEPTH stages.
REQ-011 Port: halt_req  in  1  stop accepting input and drain.
REQ-012 Port: resume  in  1  leave HALTED.
REQ-013 Port: out_ctrl  out  W  bundle in stage STAGES-1, zero when invalid.
REQ-014 Port: out_valid  out  1  valid bit of stage STAGES-1.
REQ-015 Port: stage_valid  out  STAGES  valid bit of every stage.
REQ-016 Port: occupancy  out  clog2(STAGES+1)  count of valid stages.
REQ-017 Port: drained  out  1  state is HALTED.
REQ-018 Port: bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-019 hold[k] SHALL be the OR of stall_at[j] for all j>=k (stall propagates toward stage 0).
REQ-020 Stage k (k>0) with hold[k]=0 SHALL load stage k-1 contents; with hold[k]=1 it SHALL keep its contents.
REQ-021 When hold[k-1]=1 and hold[k]=0, stage k SHALL load a bubble: valid=0, ctrl=0.
REQ-022 Stage 0 with hold[0]=0 SHALL load {in_valid, in_ctrl} when in_ready=1, else a bubble.
REQ-023 in_ready SHALL equal (state==RUN) && !hold[0] && !flush, combinationally.
REQ-024 flush SHALL force stages 0..FLUSH_DEPTH-1 to bubble, overriding hold and load, in the same edge.
REQ-025 Stages >= FLUSH_DEPTH SHALL be unaffected by flush except through REQ-020/021.
REQ-026 Invariant: any stage with valid=0 SHALL hold ctrl=0; out_ctrl is never non-zero while out_valid=0.
REQ-027 Latency: an accepted bundle with no stalls SHALL appear on out_ctrl exactly STAGES cycles after acceptance.
REQ-028 FSM states RUN, DRAIN, HALTED; RUN->DRAIN on halt_req; DRAIN->HALTED on the edge where all stage_valid are 0 after update; HALTED->RUN on resume; halt_req in DRAIN/HALTED ignored.
REQ-029 halt_req and resume together in HALTED SHALL stay HALTED; in RUN SHALL go to DRAIN.
REQ-030 occupancy SHALL be the registered popcount of stage_valid.
REQ-031 bubble_cnt SHALL increment by the number of REQ-021 bubbles created per cycle (flush bubbles excluded), saturating at 0xFFFF.

Reset
REQ-032 reset SHALL clear all stage valid and ctrl bits, occupancy, bubble_cnt, and set state RUN; out_ctrl=0, out_valid=0, drained=0, in_ready=1 (absent stall/flush) on the first cycle after reset.
REQ-033 reset SHALL override flush, stall_at and halt_req; reset mid-drain SHALL return to RUN.

Structure
REQ-034 FSM state encoding and the bubble constant SHALL live in the shared processor package.
REQ-035 One sub-module, ctrl_pipe_stage (one valid+ctrl register with load/hold/bubble/flush priority), SHALL be instantiated STAGES times by generate.

Verification (W=8, STAGES=3, FLUSH_DEPTH=1)
REQ-036 Stream 0x11,0x22,0x33 valid, no stall -> out_ctrl 0x11,0x22,0x33 on cycles 3,4,5 after first acceptance, occupancy reaches 3.
REQ-037 stall_at=3'b010 for 2 cycles with pipe full -> stages 0,1 hold, stage 2 gets bubbles, out_valid=0 for 2 cycles, bubble_cnt=2, in_ready=0.
REQ-038 flush with stall_at[0]=1 and stage 0=0x44 -> stage 0 becomes valid=0 ctrl=0 next cycle; stages 1,2 advance/hold normally.
REQ-039 halt_req with 3 valid stages, no stall -> in_ready=0 immediately, drained=1 after 3 cycles; resume -> in_ready=1 next cycle.
REQ-040 reset asserted during DRAIN with occupancy 2 -> next cycle all stage_valid=0, state RUN, bubble_cnt=0.
REQ-041 Force 65536 stall-induced bubbles -> bubble_cnt holds at 0xFFFF.
